// File: rtl/id_ex_stage_pkg.sv
// Shared AURA16 definitions for the ID/EX stage: default widths, ALU opcodes,
// and the EX control bundle with its all-zero NOP value.
package id_ex_stage_pkg;

    localparam int AURA_DATA_W  = 16;
    localparam int AURA_REG_AW  = 3;
    localparam int AURA_ALUOP_W = 3;
    localparam int AURA_CNT_W   = 16;

    typedef enum logic [AURA_ALUOP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    alu_src;
        logic [AURA_ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // A bubble must never write the RF or memory, so NOP is simply all-zero.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and front-end stall request.
module hazard_detect #(
    parameter int REG_AW = 3
) (
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              lu,
    output logic              stall_if_id
);

    // R0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu = ex_valid & ex_mem_read & (ex_write_reg != '0) & id_valid &
                ((ex_write_reg == id_rs) | (id_uses_rt & (ex_write_reg == id_rt)));

    assign stall_if_id = ~rst & (ex_hold | (lu & ~flush));

endmodule

// File: rtl/id_ex_stage.sv
// AURA16 ID/EX pipeline register: one bubble per load-use hazard, branch flush,
// EX hold, and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = AURA_DATA_W,
    parameter int REG_AW = AURA_REG_AW,
    parameter int CNT_W  = AURA_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs,
    input  logic [REG_AW-1:0]       id_rt,
    input  logic                    id_uses_rt,
    input  logic [REG_AW-1:0]       id_write_reg,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic                    id_mem_to_reg,
    input  logic                    id_alu_src,
    input  logic [AURA_ALUOP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]       id_rd1,
    input  logic [DATA_W-1:0]       id_rd2,
    input  logic [DATA_W-1:0]       id_imm,
    input  logic                    flush,
    input  logic                    ex_hold,
    output logic                    stall_if_id,
    output logic                    ex_valid,
    output logic [REG_AW-1:0]       ex_rs,
    output logic [REG_AW-1:0]       ex_rt,
    output logic [REG_AW-1:0]       ex_write_reg,
    output logic                    ex_reg_write,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_mem_to_reg,
    output logic                    ex_alu_src,
    output logic [AURA_ALUOP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]       ex_rd1,
    output logic [DATA_W-1:0]       ex_rd2,
    output logic [DATA_W-1:0]       ex_imm,
    output logic [CNT_W-1:0]        stall_count
);

    logic  lu;
    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_write_reg (ex_write_reg),
        .flush        (flush),
        .ex_hold      (ex_hold),
        .lu           (lu),
        .stall_if_id  (stall_if_id)
    );

    assign id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       alu_src:    id_alu_src,
                       alu_op:     id_alu_op};

    // Hold freezes everything, including a pending flush (its source re-presents it).
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_write_reg <= '0;
            ex_ctrl      <= CTRL_NOP;
            ex_rd1       <= '0;
            ex_rd2       <= '0;
            ex_imm       <= '0;
        end else if (!ex_hold) begin
            if (flush || lu) begin
                ex_valid     <= 1'b0;
                ex_rs        <= '0;
                ex_rt        <= '0;
                ex_write_reg <= '0;
                ex_ctrl      <= CTRL_NOP;
                ex_rd1       <= '0;
                ex_rd2       <= '0;
                ex_imm       <= '0;
            end else begin
                ex_valid     <= id_valid;
                ex_rs        <= id_rs;
                ex_rt        <= id_rt;
                ex_write_reg <= id_write_reg;
                ex_ctrl      <= id_valid ? id_ctrl : CTRL_NOP;
                ex_rd1       <= id_rd1;
                ex_rd2       <= id_rd2;
                ex_imm       <= id_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!ex_hold && !flush && lu && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule
